psg_nch: RTL and testbench



---
 rtl/psg_pkg.sv | 25 ++
 rtl/psg_env.sv | 83 ++++++++
 rtl/psg_nch.sv | 197 +++++++++++++++++++
 tb/tb_psg_nch.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psg_pkg.sv
// Shared constants and types for the N-channel PSG.
package psg_pkg;

  // Register map; per-channel banks are base + channel index (tone is base + 2*i).
  localparam logic [5:0] REG_TONE_BASE = 6'h00;
  localparam logic [5:0] REG_NOISE     = 6'h10;
  localparam logic [5:0] REG_TDIS      = 6'h11;
  localparam logic [5:0] REG_NDIS      = 6'h12;
  localparam logic [5:0] REG_VOL_BASE  = 6'h18;
  localparam logic [5:0] REG_ENV_LO    = 6'h20;
  localparam logic [5:0] REG_ENV_HI    = 6'h21;
  localparam logic [5:0] REG_SHAPE     = 6'h22;
  localparam logic [5:0] REG_PAN_BASE  = 6'h28;

  // Envelope shape bits: C (continue), At (attack), Al (alternate), H (hold).
  localparam int unsigned SHAPE_H  = 0;
  localparam int unsigned SHAPE_AL = 1;
  localparam int unsigned SHAPE_AT = 2;
  localparam int unsigned SHAPE_C  = 3;

  typedef logic [3:0] env_shape_t;

  typedef enum logic [1:0] {RAMP_UP, RAMP_DOWN, HOLD} env_state_t;

endpackage

// File: rtl/psg_env.sv
// Envelope generator: period counter plus 5-bit level shape state machine.
module psg_env
  import psg_pkg::*;
#(
  parameter int unsigned ENV_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ce,
  input  logic             tick,
  input  logic             restart_arm,
  input  logic [ENV_W-1:0] period,
  input  env_shape_t       shape,
  output logic [4:0]       level
);

  env_state_t       state, state_nx;
  logic [4:0]       level_nx;
  logic [ENV_W-1:0] cnt, cnt_nx, limit;
  logic             pending, pending_nx;
  logic             step, at_end;

  assign limit = (period == '0) ? '0 : period - ENV_W'(1);
  assign step  = tick && (cnt >= limit);

  // Next-state: a pending restart wins over a step in the same CE.
  always_comb begin
    state_nx   = state;
    level_nx   = level;
    cnt_nx     = cnt;
    pending_nx = pending;
    at_end     = ((state == RAMP_UP) && (level == '1)) ||
                 ((state == RAMP_DOWN) && (level == '0));
    if (ce) begin
      if (pending) begin
        pending_nx = 1'b0;
        cnt_nx     = '0;
        if (shape[SHAPE_AT]) begin
          level_nx = '0;
          state_nx = RAMP_UP;
        end else begin
          level_nx = '1;
          state_nx = RAMP_DOWN;
        end
      end else if (tick) begin
        cnt_nx = step ? '0 : cnt + ENV_W'(1);
        if (step && (state != HOLD)) begin
          if (!at_end) begin
            level_nx = (state == RAMP_UP) ? level + 5'd1 : level - 5'd1;
          end else if (!shape[SHAPE_C]) begin
            level_nx = '0;
            state_nx = HOLD;
          end else if (shape[SHAPE_H]) begin
            level_nx = shape[SHAPE_AL] ? ~level : level;
            state_nx = HOLD;
          end else if (shape[SHAPE_AL]) begin
            state_nx = (state == RAMP_UP) ? RAMP_DOWN : RAMP_UP;
          end else begin
            // End value inverted is the wrap target (31->0 or 0->31).
            level_nx = ~level;
          end
        end
      end
    end
    if (restart_arm) pending_nx = 1'b1;
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= HOLD;
      level   <= '0;
      cnt     <= '0;
      pending <= 1'b0;
    end else begin
      state   <= state_nx;
      level   <= level_nx;
      cnt     <= cnt_nx;
      pending <= pending_nx;
    end
  end

endmodule

// File: rtl/psg_nch.sv
// N-channel PSG: register file, tone/noise generators, level and stereo mix.
module psg_nch
  import psg_pkg::*;
#(
  parameter int unsigned NCH      = 3,
  parameter int unsigned TONE_W   = 12,
  parameter int unsigned NOISE_W  = 5,
  parameter int unsigned ENV_W    = 16,
  parameter int unsigned PRESCALE = 8
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           CE,
  input  logic                           WE,
  input  logic [5:0]                     ADDR,
  input  logic [7:0]                     DI,
  output logic [7:0]                     DO,
  output logic [NCH*5-1:0]               LEVEL,
  output logic [5+$clog2(NCH+1)-1:0]     MIX_L,
  output logic [5+$clog2(NCH+1)-1:0]     MIX_R,
  output logic [NCH-1:0]                 ACTIVE
);

  localparam int unsigned MIX_W = 5 + $clog2(NCH + 1);
  localparam int unsigned PW    = $clog2(PRESCALE);

  logic [TONE_W-1:0]  tone_per [NCH];
  logic [4:0]         vol      [NCH];
  logic [1:0]         pan      [NCH];
  logic [4:0]         level_r  [NCH];
  logic [NOISE_W-1:0] noise_per, noise_cnt;
  logic [NCH-1:0]     tone_dis, noise_dis, tone_op;
  logic [ENV_W-1:0]   env_per;
  env_shape_t         shape;
  logic [4:0]         env_level;
  logic [16:0]        lfsr;
  logic [PW-1:0]      presc;
  logic               half, tick, noise_tick, noise_op, shape_wr;
  logic [MIX_W-1:0]   mix_l_nx, mix_r_nx;

  assign shape_wr   = WE && (ADDR == REG_SHAPE);
  assign tick       = CE && (presc == PW'(PRESCALE - 1));
  assign noise_tick = tick && half;
  assign noise_op   = (noise_per != '0) & lfsr[0];

  // Register writes; hi bytes are truncated to the declared width on store.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        tone_per[i] <= '0;
        vol[i]      <= '0;
        pan[i]      <= 2'b11;
      end
      noise_per <= '0;
      tone_dis  <= '1;
      noise_dis <= '1;
      env_per   <= '0;
      shape     <= '0;
    end else if (WE) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (ADDR == REG_TONE_BASE + 6'(2 * i))     tone_per[i][7:0] <= DI;
        if (ADDR == REG_TONE_BASE + 6'(2 * i + 1)) tone_per[i] <= TONE_W'({DI, tone_per[i][7:0]});
        if (ADDR == REG_VOL_BASE + 6'(i))          vol[i] <= DI[4:0];
        if (ADDR == REG_PAN_BASE + 6'(i))          pan[i] <= DI[1:0];
      end
      case (ADDR)
        REG_NOISE:  noise_per    <= DI[NOISE_W-1:0];
        REG_TDIS:   tone_dis     <= DI[NCH-1:0];
        REG_NDIS:   noise_dis    <= DI[NCH-1:0];
        REG_ENV_LO: env_per[7:0] <= DI;
        REG_ENV_HI: env_per      <= ENV_W'({DI, env_per[7:0]});
        REG_SHAPE:  shape        <= DI[3:0];
        default: ;
      endcase
    end
  end

  // Combinational readback; unmapped addresses and unused bits read zero.
  always_comb begin
    DO = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (ADDR == REG_TONE_BASE + 6'(2 * i))     DO = tone_per[i][7:0];
      if (ADDR == REG_TONE_BASE + 6'(2 * i + 1)) DO = 8'(tone_per[i] >> 8);
      if (ADDR == REG_VOL_BASE + 6'(i))          DO = {3'b000, vol[i]};
      if (ADDR == REG_PAN_BASE + 6'(i))          DO = {6'b000000, pan[i]};
    end
    case (ADDR)
      REG_NOISE:  DO = 8'(noise_per);
      REG_TDIS:   DO = 8'(tone_dis);
      REG_NDIS:   DO = 8'(noise_dis);
      REG_ENV_LO: DO = env_per[7:0];
      REG_ENV_HI: DO = 8'(env_per >> 8);
      REG_SHAPE:  DO = {4'b0000, shape};
      default: ;
    endcase
  end

  // Prescaler: one tick per PRESCALE CEs, noise every second tick.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      presc <= '0;
      half  <= 1'b0;
    end else if (CE) begin
      presc <= presc + PW'(1);
      if (tick) half <= ~half;
    end
  end

  // Noise period counter and 17-bit LFSR.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      noise_cnt <= '0;
      lfsr      <= 17'd1;
    end else if (noise_tick) begin
      if (noise_per == '0) begin
        noise_cnt <= '0;
      end else if (noise_cnt >= noise_per - NOISE_W'(1)) begin
        noise_cnt <= '0;
        lfsr      <= {lfsr[0] ^ lfsr[3], lfsr[16:1]};
      end else begin
        noise_cnt <= noise_cnt + NOISE_W'(1);
      end
    end
  end

  psg_env #(.ENV_W(ENV_W)) u_env (
    .CLK         (CLK),
    .RESET       (RESET),
    .ce          (CE),
    .tick        (tick),
    .restart_arm (shape_wr),
    .period      (env_per),
    .shape       (shape),
    .level       (env_level)
  );

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [TONE_W-1:0] cnt;
    logic              op;
    logic              gate;
    logic [4:0]        lvl_nx;

    // Tone counter: half-period of P ticks, P = 0 parks the output low.
    always_ff @(posedge CLK) begin
      if (RESET) begin
        cnt <= '0;
        op  <= 1'b0;
      end else if (tick) begin
        if (tone_per[g] == '0) begin
          cnt <= '0;
          op  <= 1'b0;
        end else if (cnt >= tone_per[g] - TONE_W'(1)) begin
          cnt <= '0;
          op  <= ~op;
        end else begin
          cnt <= cnt + TONE_W'(1);
        end
      end
    end

    assign tone_op[g] = op;
    assign gate   = (tone_dis[g] | tone_op[g]) & (noise_dis[g] | noise_op);
    assign lvl_nx = !gate ? 5'd0 :
                    vol[g][4] ? env_level : {vol[g][3:0], vol[g][3]};

    // Output level sampled on CE.
    always_ff @(posedge CLK) begin
      if (RESET)   level_r[g] <= '0;
      else if (CE) level_r[g] <= lvl_nx;
    end

    assign LEVEL[5*g +: 5] = level_r[g];
    assign ACTIVE[g]       = ~tone_dis[g] | ~noise_dis[g];
  end

  // Stereo sums of the registered levels.
  always_comb begin
    mix_l_nx = '0;
    mix_r_nx = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (pan[i][1]) mix_l_nx = mix_l_nx + MIX_W'(level_r[i]);
      if (pan[i][0]) mix_r_nx = mix_r_nx + MIX_W'(level_r[i]);
    end
  end

  // Mix register, one CLK behind LEVEL.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      MIX_L <= '0;
      MIX_R <= '0;
    end else begin
      MIX_L <= mix_l_nx;
      MIX_R <= mix_r_nx;
    end
  end

endmodule

// File: tb/tb_psg_nch.sv
// Self-checking bench for psg_nch (NCH=3, PRESCALE=8, CE every CLK when running).
module tb_psg_nch;

  logic        CLK = 1'b0;
  logic        RESET, CE, WE;
  logic [5:0]  ADDR;
  logic [7:0]  DI, DO;
  logic [14:0] LEVEL;
  logic [6:0]  MIX_L, MIX_R;
  logic [2:0]  ACTIVE;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [14:0] level;
    logic [6:0]  mix_l;
    logic [6:0]  mix_r;
  } exp_t;
  typedef struct {
    logic [5:0] addr;
    logic [7:0] data;
  } rd_t;

  exp_t sb[$];
  rd_t  rq[$];
  exp_t e;
  rd_t  r;

  psg_nch #(.NCH(3), .TONE_W(12), .NOISE_W(5), .ENV_W(16), .PRESCALE(8)) dut (
    .CLK(CLK), .RESET(RESET), .CE(CE), .WE(WE), .ADDR(ADDR), .DI(DI), .DO(DO),
    .LEVEL(LEVEL), .MIX_L(MIX_L), .MIX_R(MIX_R), .ACTIVE(ACTIVE)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Square wave after n CE edges with a given half-period in CE edges (LEVEL lags by one CE).
  function automatic int sq(int n, int half);
    if (n < 1) return 0;
    return ((n - 1) / half) % 2;
  endfunction

  function automatic int tri_lvl(int k);
    if (k <= 31) return k;
    if (k <= 63) return 63 - k;
    return k - 64;
  endfunction

  function automatic int hold_lvl(int k, bit alt);
    if (k <= 31) return 31 - k;
    return alt ? 31 : 0;
  endfunction

  task automatic do_reset();
    RESET = 1'b1; CE = 1'b0; WE = 1'b0; ADDR = '0; DI = '0;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    ADDR = a; DI = d; WE = 1'b1;
    @(posedge CLK);
    #1 WE = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    ADDR = 6'h00;
    #1;
    tests++;
    if (LEVEL !== 15'd0 || MIX_L !== 7'd0 || MIX_R !== 7'd0 || DO !== 8'h00 || ACTIVE !== 3'b000) begin
      fails++;
      $display("FAIL reset: LEVEL=%h MIX_L=%0d MIX_R=%0d DO=%h ACTIVE=%b, expected 0 0 0 00 000",
               LEVEL, MIX_L, MIX_R, DO, ACTIVE);
    end
  endtask

  task automatic test_tone();
    int l0, p0;
    do_reset();
    wr(6'h00, 8'h02);
    wr(6'h11, 8'h06);
    wr(6'h18, 8'h0F);
    tests++;
    if (ACTIVE !== 3'b001) begin
      fails++;
      $display("FAIL tone_active: ACTIVE=%b expected 001", ACTIVE);
    end
    for (int n = 1; n <= 64; n++) begin
      l0 = 31 * sq(n, 16);
      p0 = 31 * sq(n - 1, 16);
      e.level = 15'(l0); e.mix_l = 7'(p0); e.mix_r = 7'(p0);
      sb.push_back(e);
    end
    CE = 1'b1;
    while (sb.size() > 0) begin
      @(posedge CLK); #1;
      e = sb.pop_front();
      tests++;
      if (LEVEL !== e.level || MIX_L !== e.mix_l || MIX_R !== e.mix_r) begin
        fails++;
        $display("FAIL tone: LEVEL=%h MIX_L=%0d MIX_R=%0d, expected %h %0d %0d",
                 LEVEL, MIX_L, MIX_R, e.level, e.mix_l, e.mix_r);
      end
    end
    CE = 1'b0;
  endtask

  task automatic test_pan();
    int l0, l1, p0, p1;
    do_reset();
    wr(6'h00, 8'h02);
    wr(6'h02, 8'h01);
    wr(6'h18, 8'h0F);
    wr(6'h19, 8'h08);
    wr(6'h11, 8'h04);
    wr(6'h29, 8'h02);
    for (int n = 1; n <= 64; n++) begin
      l0 = 31 * sq(n, 16);     l1 = 17 * sq(n, 8);
      p0 = 31 * sq(n - 1, 16); p1 = 17 * sq(n - 1, 8);
      e.level = 15'(l0) | (15'(l1) << 5);
      e.mix_l = 7'(p0 + p1);
      e.mix_r = 7'(p0);
      sb.push_back(e);
    end
    CE = 1'b1;
    while (sb.size() > 0) begin
      @(posedge CLK); #1;
      e = sb.pop_front();
      tests++;
      if (LEVEL !== e.level || MIX_L !== e.mix_l || MIX_R !== e.mix_r) begin
        fails++;
        $display("FAIL pan: LEVEL=%h MIX_L=%0d MIX_R=%0d, expected %h %0d %0d",
                 LEVEL, MIX_L, MIX_R, e.level, e.mix_l, e.mix_r);
      end
    end
    CE = 1'b0;
    // All three channels at full scale, both sides.
    wr(6'h11, 8'h07);
    wr(6'h19, 8'h0F);
    wr(6'h1A, 8'h0F);
    wr(6'h29, 8'h03);
    e.level = 15'h7FFF; e.mix_l = 7'd93; e.mix_r = 7'd93;
    sb.push_back(e);
    CE = 1'b1;
    repeat (2) @(posedge CLK);
    #1 CE = 1'b0;
    e = sb.pop_front();
    tests++;
    if (LEVEL !== e.level || MIX_L !== e.mix_l || MIX_R !== e.mix_r) begin
      fails++;
      $display("FAIL pan_full: LEVEL=%h MIX_L=%0d MIX_R=%0d, expected %h %0d %0d",
               LEVEL, MIX_L, MIX_R, e.level, e.mix_l, e.mix_r);
    end
  endtask

  task automatic test_env_tri();
    do_reset();
    wr(6'h20, 8'h01);
    wr(6'h11, 8'h07);
    wr(6'h18, 8'h10);
    wr(6'h22, 8'h0E);
    for (int n = 1; n <= 300; n++) begin
      e.level = 15'((n == 1) ? 0 : tri_lvl((n - 1) / 8));
      e.mix_l = '0; e.mix_r = '0;
      sb.push_back(e);
    end
    CE = 1'b1;
    while (sb.size() > 0) begin
      @(posedge CLK); #1;
      e = sb.pop_front();
      tests++;
      if (LEVEL !== e.level) begin
        fails++;
        $display("FAIL env_tri: LEVEL=%h expected %h", LEVEL, e.level);
      end
    end
    CE = 1'b0;
    // Shape rewrite restarts the ramp from 0 at the next CE.
    wr(6'h22, 8'h0E);
    for (int n = 301; n <= 340; n++) begin
      e.level = 15'((n == 301) ? tri_lvl(37) : ((n - 1) / 8) - 37);
      sb.push_back(e);
    end
    CE = 1'b1;
    while (sb.size() > 0) begin
      @(posedge CLK); #1;
      e = sb.pop_front();
      tests++;
      if (LEVEL !== e.level) begin
        fails++;
        $display("FAIL env_restart: LEVEL=%h expected %h", LEVEL, e.level);
      end
    end
    CE = 1'b0;
  endtask

  task automatic test_env_hold();
    logic [7:0] shp;
    for (int s = 0; s < 2; s++) begin
      shp = (s == 0) ? 8'h09 : 8'h0B;
      do_reset();
      wr(6'h20, 8'h01);
      wr(6'h11, 8'h07);
      wr(6'h18, 8'h10);
      wr(6'h22, shp);
      for (int n = 1; n <= 400; n++) begin
        e.level = 15'((n == 1) ? 0 : hold_lvl((n - 1) / 8, s == 1));
        e.mix_l = '0; e.mix_r = '0;
        sb.push_back(e);
      end
      CE = 1'b1;
      while (sb.size() > 0) begin
        @(posedge CLK); #1;
        e = sb.pop_front();
        tests++;
        if (LEVEL !== e.level) begin
          fails++;
          $display("FAIL env_hold shape=%h: LEVEL=%h expected %h", shp, LEVEL, e.level);
        end
      end
      CE = 1'b0;
    end
  endtask

  task automatic test_noise();
    logic [16:0] l;
    bit          b0s [41];
    l = 17'd1;
    for (int m = 0; m <= 40; m++) begin
      b0s[m] = l[0];
      l = {l[0] ^ l[3], l[16:1]};
    end
    do_reset();
    wr(6'h10, 8'h01);
    wr(6'h12, 8'h03);
    wr(6'h11, 8'h07);
    wr(6'h1A, 8'h0F);
    for (int n = 1; n <= 640; n++) begin
      e.level = b0s[(n - 1) / 16] ? 15'h7C00 : 15'h0000;
      e.mix_l = '0; e.mix_r = '0;
      sb.push_back(e);
    end
    CE = 1'b1;
    while (sb.size() > 0) begin
      @(posedge CLK); #1;
      e = sb.pop_front();
      tests++;
      if (LEVEL !== e.level) begin
        fails++;
        $display("FAIL noise: LEVEL=%h expected %h", LEVEL, e.level);
      end
    end
    CE = 1'b0;
    // Period 0 silences noise even though the seed's b0 is 1.
    do_reset();
    wr(6'h12, 8'h03);
    wr(6'h11, 8'h07);
    wr(6'h1A, 8'h0F);
    for (int n = 1; n <= 40; n++) begin
      e.level = 15'h0000;
      sb.push_back(e);
    end
    CE = 1'b1;
    while (sb.size() > 0) begin
      @(posedge CLK); #1;
      e = sb.pop_front();
      tests++;
      if (LEVEL !== e.level) begin
        fails++;
        $display("FAIL noise_off: LEVEL=%h expected %h", LEVEL, e.level);
      end
    end
    CE = 1'b0;
  endtask

  task automatic test_readback();
    logic [5:0] wa [10] = '{6'h01, 6'h10, 6'h30, 6'h18, 6'h22, 6'h21, 6'h1B, 6'h2B, 6'h07, 6'h29};
    logic [7:0] wd [10] = '{8'h0F, 8'h1F, 8'h00, 8'h1F, 8'h0F, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h03};
    do_reset();
    r.addr = 6'h11; r.data = 8'h07; rq.push_back(r);
    r.addr = 6'h12; r.data = 8'h07; rq.push_back(r);
    r.addr = 6'h28; r.data = 8'h03; rq.push_back(r);
    r.addr = 6'h2A; r.data = 8'h03; rq.push_back(r);
    r.addr = 6'h2B; r.data = 8'h00; rq.push_back(r);
    r.addr = 6'h00; r.data = 8'h00; rq.push_back(r);
    while (rq.size() > 0) begin
      r = rq.pop_front();
      ADDR = r.addr; #1;
      tests++;
      if (DO !== r.data) begin
        fails++;
        $display("FAIL readback_reset addr=%h: DO=%h expected %h", r.addr, DO, r.data);
      end
    end
    for (int i = 0; i < 10; i++) begin
      wr(wa[i], 8'hFF);
      r.addr = wa[i]; r.data = wd[i]; rq.push_back(r);
    end
    while (rq.size() > 0) begin
      r = rq.pop_front();
      ADDR = r.addr; #1;
      tests++;
      if (DO !== r.data) begin
        fails++;
        $display("FAIL readback addr=%h: DO=%h expected %h", r.addr, DO, r.data);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    wr(6'h00, 8'h02);
    wr(6'h11, 8'h06);
    wr(6'h18, 8'h0F);
    CE = 1'b1;
    repeat (20) @(posedge CLK);
    #1;
    tests++;
    if (LEVEL !== 15'd31) begin
      fails++;
      $display("FAIL reset_mid_pre: LEVEL=%h expected %h", LEVEL, 15'd31);
    end
    // Reset with a concurrent write and CE: reset must win.
    RESET = 1'b1; WE = 1'b1; ADDR = 6'h11; DI = 8'h00;
    @(posedge CLK);
    #1 RESET = 1'b0; WE = 1'b0; CE = 1'b0;
    tests++;
    if (LEVEL !== 15'd0 || MIX_L !== 7'd0 || MIX_R !== 7'd0) begin
      fails++;
      $display("FAIL reset_mid_out: LEVEL=%h MIX_L=%0d MIX_R=%0d expected 0 0 0", LEVEL, MIX_L, MIX_R);
    end
    r.addr = 6'h11; r.data = 8'h07; rq.push_back(r);
    r.addr = 6'h12; r.data = 8'h07; rq.push_back(r);
    r.addr = 6'h00; r.data = 8'h00; rq.push_back(r);
    while (rq.size() > 0) begin
      r = rq.pop_front();
      ADDR = r.addr; #1;
      tests++;
      if (DO !== r.data) begin
        fails++;
        $display("FAIL reset_mid_reg addr=%h: DO=%h expected %h", r.addr, DO, r.data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_tone();
    test_pan();
    test_env_tri();
    test_env_hold();
    test_noise();
    test_readback();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
